// File: rtl/store_buffer_if.sv
// Store buffer bus: store offer, load probe, data-memory port and occupancy.
// master = pipeline side driving stores/loads, slave = the store buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [63:0]   st_addr;
    logic [63:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [63:0]   ld_addr;
    logic          fwd_hit;
    logic [63:0]   fwd_data;
    logic          ld_conflict;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, fwd_hit, fwd_data, ld_conflict,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        input  count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, fwd_hit, fwd_data, ld_conflict,
        output mem_addr, mem_wdata, mem_write, mem_read,
        output count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Doubleword store buffer: circular FIFO of stores drained to memory when the
// port is free, with youngest-match load forwarding and partial-overlap detect.
// Ports: clk, reset (sync, active high), bus (store_buffer_if.slave).
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [63:0]      addr_q [DEPTH];
    logic [63:0]      addr_d [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [63:0]      data_d [DEPTH];

    logic             ready;
    logic             push;
    logic             drain;
    logic             ld_on;
    logic             wr_on;
    logic             hit;
    logic             conf;
    logic [63:0]      hit_data;
    logic [AW-1:0]    idx;
    logic [64:0]      ld_lo, ld_hi;
    logic [64:0]      e_lo, e_hi;

    // Queue control: loads own the memory port, so a drain only happens
    // on cycles without a load.
    always_comb begin
        ready   = count_q < CW'(DEPTH);
        push    = bus.st_valid && ready;
        drain   = !bus.ld_valid && (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q]  = bus.st_addr;
            data_d[tail_q]  = bus.st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        unique case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Forwarding scans oldest to youngest so the last exact match wins.
    // Ranges use 65-bit ends so addresses near 2^64 do not wrap.
    always_comb begin
        hit      = 1'b0;
        conf     = 1'b0;
        hit_data = '0;
        idx      = '0;
        e_lo     = '0;
        e_hi     = '0;
        ld_lo    = {1'b0, bus.ld_addr};
        ld_hi    = ld_lo + 65'd8;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head_q + AW'(i);
            e_lo = {1'b0, addr_q[idx]};
            e_hi = e_lo + 65'd8;
            if (valid_q[idx]) begin
                if (addr_q[idx] == bus.ld_addr) begin
                    hit      = 1'b1;
                    hit_data = data_q[idx];
                end else if (e_lo < ld_hi && ld_lo < e_hi) begin
                    conf = 1'b1;
                end
            end
        end
    end

    assign ld_on = bus.ld_valid && !reset;
    assign wr_on = drain && !reset;

    assign bus.st_ready    = reset || ready;
    assign bus.count       = reset ? '0 : count_q;
    assign bus.empty       = reset || (count_q == '0);
    assign bus.mem_read    = ld_on;
    assign bus.mem_write   = wr_on;
    assign bus.mem_addr    = ld_on ? bus.ld_addr :
                             wr_on ? addr_q[head_q] : '0;
    assign bus.mem_wdata   = wr_on ? data_q[head_q] : '0;
    assign bus.ld_conflict = ld_on && conf;
    assign bus.fwd_hit     = ld_on && hit && !conf;
    assign bus.fwd_data    = bus.fwd_hit ? hit_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer plus hand-written sequences.
// Prints one TB_RESULT summary line.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [63:0] sa;
        logic [63:0] sd;
        logic        lv;
        logic [63:0] la;
        logic [2:0]  cnt;
        logic        rdy;
        logic        hit;
        logic [63:0] fd;
        logic        conf;
        logic        mw;
        logic        mr;
        logic [63:0] ma;
        logic [63:0] mwd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rst, input logic sv, input logic [63:0] sa,
        input logic [63:0] sd, input logic lv, input logic [63:0] la,
        input logic [2:0] cnt, input logic rdy, input logic hit,
        input logic [63:0] fd, input logic conf, input logic mw,
        input logic mr, input logic [63:0] ma, input logic [63:0] mwd
    );
        vec_t v;
        v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd;
        v.lv = lv; v.la = la; v.cnt = cnt; v.rdy = rdy;
        v.hit = hit; v.fd = fd; v.conf = conf; v.mw = mw;
        v.mr = mr; v.ma = ma; v.mwd = mwd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic sv,
                         input logic [63:0] sa, input logic [63:0] sd,
                         input logic lv, input logic [63:0] la);
        reset        = rst;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    localparam logic [63:0] LD = 64'h100;
    localparam logic [63:0] HI = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        //  rst sv sa      sd    lv la     cnt rdy hit fd    cf mw mr ma      mwd
        add(1, 1, 'h50, 'h5,  1, 'h50,  0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(1, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 1, 'h10, 'hAA, 0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 0, 0,    0,    0, 0,     1, 1, 0, 0,    0, 1, 0, 'h10,  'hAA);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 1, 'h08, 'h11, 1, 'h08,  0, 1, 0, 0,    0, 0, 1, 'h08,  0);
        add(0, 1, 'h08, 'h22, 1, 'h08,  1, 1, 1, 'h11, 0, 0, 1, 'h08,  0);
        add(0, 0, 0,    0,    1, 'h08,  2, 1, 1, 'h22, 0, 0, 1, 'h08,  0);
        add(0, 0, 0,    0,    1, 'h0C,  2, 1, 0, 0,    1, 0, 1, 'h0C,  0);
        add(0, 0, 0,    0,    1, 'h10,  2, 1, 0, 0,    0, 0, 1, 'h10,  0);
        add(0, 0, 0,    0,    1, 'h01,  2, 1, 0, 0,    1, 0, 1, 'h01,  0);
        add(0, 0, 0,    0,    0, 0,     2, 1, 0, 0,    0, 1, 0, 'h08,  'h11);
        add(0, 0, 0,    0,    0, 0,     1, 1, 0, 0,    0, 1, 0, 'h08,  'h22);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 1, 'h20, 1,    1, LD,    0, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h28, 2,    1, LD,    1, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h30, 3,    1, LD,    2, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h38, 4,    1, LD,    3, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h40, 5,    1, LD,    4, 0, 0, 0,    0, 0, 1, LD,    0);
        add(0, 0, 0,    0,    1, 'h30,  4, 0, 1, 3,    0, 0, 1, 'h30,  0);
        add(0, 0, 0,    0,    0, 0,     4, 0, 0, 0,    0, 1, 0, 'h20,  1);
        add(0, 0, 0,    0,    0, 0,     3, 1, 0, 0,    0, 1, 0, 'h28,  2);
        add(0, 0, 0,    0,    0, 0,     2, 1, 0, 0,    0, 1, 0, 'h30,  3);
        add(0, 0, 0,    0,    0, 0,     1, 1, 0, 0,    0, 1, 0, 'h38,  4);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 1, 'h50, 6,    1, LD,    0, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h58, 7,    1, LD,    1, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h60, 8,    1, LD,    2, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 1, 'h68, 9,    0, 0,     3, 1, 0, 0,    0, 1, 0, 'h50,  6);
        add(0, 0, 0,    0,    0, 0,     3, 1, 0, 0,    0, 1, 0, 'h58,  7);
        add(0, 1, 'h70, 'hA,  1, LD,    2, 1, 0, 0,    0, 0, 1, LD,    0);
        add(0, 0, 0,    0,    0, 0,     3, 1, 0, 0,    0, 1, 0, 'h60,  8);
        add(1, 1, 'h90, 'hF,  0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);
        add(0, 1, HI,   'hB,  1, 'h200, 0, 1, 0, 0,    0, 0, 1, 'h200, 0);
        add(0, 0, 0,    0,    1, HI-4,  1, 1, 0, 0,    1, 0, 1, HI-4,  0);
        add(0, 0, 0,    0,    1, HI-3,  1, 1, 0, 0,    1, 0, 1, HI-3,  0);
        add(0, 0, 0,    0,    1, HI,    1, 1, 1, 'hB,  0, 0, 1, HI,    0);
        add(0, 0, 0,    0,    0, 0,     1, 1, 0, 0,    0, 1, 0, HI,    'hB);
        add(0, 0, 0,    0,    0, 0,     0, 1, 0, 0,    0, 0, 0, 0,     0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.rst, v.sv, v.sa, v.sd, v.lv, v.la);
            #1;
            chk($sformatf("v%0d.count", i), 64'(bus.count), 64'(v.cnt));
            chk($sformatf("v%0d.empty", i), 64'(bus.empty),
                64'(v.cnt == 0));
            chk($sformatf("v%0d.st_ready", i), 64'(bus.st_ready),
                64'(v.rdy));
            chk($sformatf("v%0d.fwd_hit", i), 64'(bus.fwd_hit), 64'(v.hit));
            chk($sformatf("v%0d.fwd_data", i), bus.fwd_data, v.fd);
            chk($sformatf("v%0d.ld_conflict", i), 64'(bus.ld_conflict),
                64'(v.conf));
            chk($sformatf("v%0d.mem_write", i), 64'(bus.mem_write),
                64'(v.mw));
            chk($sformatf("v%0d.mem_read", i), 64'(bus.mem_read),
                64'(v.mr));
            chk($sformatf("v%0d.mem_addr", i), bus.mem_addr, v.ma);
            chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata, v.mwd);
        end

        // Four stores to one address: the youngest forwards, then all four
        // drain unmerged and in push order.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 1, 64'h80, 64'hD0 + 64'(k), 1, 64'h300);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 64'h80);
        #1;
        chk("same.fwd_hit", 64'(bus.fwd_hit), 64'd1);
        chk("same.fwd_data", bus.fwd_data, 64'hD3);
        chk("same.count", 64'(bus.count), 64'd4);
        chk("same.st_ready", 64'(bus.st_ready), 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        begin
            int got;
            int cyc;
            got = 0;
            cyc = 0;
            while (got < 4 && cyc < 12) begin
                #1;
                if (bus.mem_write) begin
                    chk($sformatf("same.drain%0d.addr", got), bus.mem_addr,
                        64'h80);
                    chk($sformatf("same.drain%0d.data", got), bus.mem_wdata,
                        64'hD0 + 64'(got));
                    got++;
                end
                cyc++;
                @(negedge clk);
            end
            chk("same.drain_count", 64'(got), 64'd4);
        end
        #1;
        chk("same.empty_after", 64'(bus.empty), 64'd1);
        chk("same.no_extra_write", 64'(bus.mem_write), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
